// File: rtl/regarb_pkg.sv
// Shared types for the register-bus master arbiter family.
// Holds the arbiter state encoding and grant-width helpers.
package regarb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_RESP     = 2'd3
  } regarb_state_e;

  localparam int REGARB_REQ_NUM = 2;
  localparam int REGARB_GNT_W   = $clog2(REGARB_REQ_NUM);

  function automatic int regarb_gnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regarb_rr_picker.sv
// Combinational round-robin pick: first set bit of i_pend after i_rr_ptr.
// Ports: i_pend, i_rr_ptr in; o_gnt index and o_any_vld out.
module regarb_rr_picker
  import regarb_pkg::*;
#(
  parameter int REQ_NUM = 2,
  parameter int GNT_W   = regarb_gnt_w(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] i_pend,
  input  logic [GNT_W-1:0]   i_rr_ptr,
  output logic [GNT_W-1:0]   o_gnt,
  output logic               o_any_vld
);

  logic [GNT_W-1:0] w_hi;
  logic [GNT_W-1:0] w_lo;
  logic             w_hi_vld;
  logic             w_lo_vld;

  // Lowest set index above the pointer wins; otherwise wrap to lowest set.
  always_comb begin
    w_hi     = '0;
    w_lo     = '0;
    w_hi_vld = 1'b0;
    w_lo_vld = 1'b0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (i_pend[i]) begin
        w_lo     = GNT_W'(i);
        w_lo_vld = 1'b1;
        if (i > int'(i_rr_ptr)) begin
          w_hi     = GNT_W'(i);
          w_hi_vld = 1'b1;
        end
      end
    end
  end

  assign o_gnt     = w_hi_vld ? w_hi : w_lo;
  assign o_any_vld = w_lo_vld;

endmodule

// File: rtl/regarb_mst_arb.sv
// Round-robin master arbiter: REQ_NUM one-deep request buffers -> one dispatcher port.
// Ports: upstream req/addr/wr/rd/wdata/soft_rst in, ack/err/rd_data out;
// downstream req/addr/wr/rd/wdata/soft_rst out, ack/err/rd_data in.
// Build option: REGARB_TIMEOUT_EN forces err after TIMEOUT_CYCLES without ack.
module regarb_mst_arb
  import regarb_pkg::*;
#(
  parameter int REQ_NUM        = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          regarb_mst_arb_clk,
  input  logic                          regarb_mst_arb_rst,
  input  logic [REQ_NUM-1:0]            upstream__regarb_mst_arb__req_vld,
  input  logic [REQ_NUM*ADDR_WIDTH-1:0] upstream__regarb_mst_arb__addr,
  input  logic [REQ_NUM-1:0]            upstream__regarb_mst_arb__wr_en,
  input  logic [REQ_NUM-1:0]            upstream__regarb_mst_arb__rd_en,
  input  logic [REQ_NUM*DATA_WIDTH-1:0] upstream__regarb_mst_arb__wr_data,
  input  logic [REQ_NUM-1:0]            upstream__regarb_mst_arb__soft_rst,
  output logic [REQ_NUM-1:0]            regarb_mst_arb__upstream__ack_vld,
  output logic [REQ_NUM-1:0]            regarb_mst_arb__upstream__err,
  output logic [REQ_NUM*DATA_WIDTH-1:0] regarb_mst_arb__upstream__rd_data,
  output logic                          regarb_mst_arb__downstream__req_vld,
  output logic [ADDR_WIDTH-1:0]         regarb_mst_arb__downstream__addr,
  output logic                          regarb_mst_arb__downstream__wr_en,
  output logic                          regarb_mst_arb__downstream__rd_en,
  output logic [DATA_WIDTH-1:0]         regarb_mst_arb__downstream__wr_data,
  input  logic                          downstream__regarb_mst_arb__ack_vld,
  input  logic                          downstream__regarb_mst_arb__err,
  input  logic [DATA_WIDTH-1:0]         downstream__regarb_mst_arb__rd_data,
  output logic                          regarb_mst_arb__downstream__soft_rst
);

  localparam int GNT_W = regarb_gnt_w(REQ_NUM);

  regarb_state_e r_state;

  logic [REQ_NUM-1:0]    r_pend;
  logic [ADDR_WIDTH-1:0] r_pend_addr  [REQ_NUM];
  logic [DATA_WIDTH-1:0] r_pend_wdata [REQ_NUM];
  logic [REQ_NUM-1:0]    r_pend_wr;
  logic [REQ_NUM-1:0]    r_pend_rd;

  logic [GNT_W-1:0] r_gnt;
  logic [GNT_W-1:0] r_rr_ptr;

  logic                  r_ds_vld;
  logic [ADDR_WIDTH-1:0] r_ds_addr;
  logic                  r_ds_wr;
  logic                  r_ds_rd;
  logic [DATA_WIDTH-1:0] r_ds_wdata;
  logic                  r_ds_srst;

  logic [REQ_NUM-1:0]            r_up_ack;
  logic [REQ_NUM-1:0]            r_up_err;
  logic [REQ_NUM*DATA_WIDTH-1:0] r_up_rdata;

  logic [GNT_W-1:0]      w_gnt;
  logic                  w_any;
  logic [REQ_NUM-1:0]    w_clr;
  logic                  w_rsp_fire;
  logic                  w_rsp_err;
  logic [DATA_WIDTH-1:0] w_rsp_data;

`ifdef REGARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             w_tmo;
  assign w_tmo = (r_state == ST_WAIT_ACK) &&
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  regarb_rr_picker #(
    .REQ_NUM (REQ_NUM),
    .GNT_W   (GNT_W)
  ) u_pick (
    .i_pend    (r_pend),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_any_vld (w_any)
  );

  // Acks outside ISSUE/WAIT_ACK are stray or late and fall through here.
  always_comb begin
    w_rsp_fire = 1'b0;
    w_rsp_err  = 1'b0;
    w_rsp_data = '0;
    if ((r_state == ST_ISSUE || r_state == ST_WAIT_ACK) &&
        downstream__regarb_mst_arb__ack_vld) begin
      w_rsp_fire = 1'b1;
      w_rsp_err  = downstream__regarb_mst_arb__err;
      w_rsp_data = downstream__regarb_mst_arb__rd_data;
    end
`ifdef REGARB_TIMEOUT_EN
    else if (w_tmo) begin
      w_rsp_fire = 1'b1;
      w_rsp_err  = 1'b1;
    end
`endif
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      w_clr[i] = (r_state == ST_RESP) && (r_gnt == GNT_W'(i));
    end
  end

  // A buffer freed in RESP may take a new request on the same edge.
  always_ff @(posedge regarb_mst_arb_clk) begin
    if (regarb_mst_arb_rst) begin
      r_pend    <= '0;
      r_pend_wr <= '0;
      r_pend_rd <= '0;
      for (int i = 0; i < REQ_NUM; i++) begin
        r_pend_addr[i]  <= '0;
        r_pend_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (w_clr[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (upstream__regarb_mst_arb__req_vld[i] &&
            (!r_pend[i] || w_clr[i])) begin
          r_pend[i]       <= 1'b1;
          r_pend_wr[i]    <= upstream__regarb_mst_arb__wr_en[i];
          r_pend_rd[i]    <= upstream__regarb_mst_arb__rd_en[i];
          r_pend_addr[i]  <=
            upstream__regarb_mst_arb__addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          r_pend_wdata[i] <=
            upstream__regarb_mst_arb__wr_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge regarb_mst_arb_clk) begin
    if (regarb_mst_arb_rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_rr_ptr   <= GNT_W'(REQ_NUM - 1);
      r_ds_vld   <= 1'b0;
      r_ds_addr  <= '0;
      r_ds_wr    <= 1'b0;
      r_ds_rd    <= 1'b0;
      r_ds_wdata <= '0;
      r_ds_srst  <= 1'b0;
      r_up_ack   <= '0;
      r_up_err   <= '0;
      r_up_rdata <= '0;
`ifdef REGARB_TIMEOUT_EN
      r_cnt      <= '0;
`endif
    end else begin
      r_ds_vld   <= 1'b0;
      r_ds_srst  <= |upstream__regarb_mst_arb__soft_rst;
      r_up_ack   <= '0;
      r_up_err   <= '0;
      r_up_rdata <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_gnt;
            r_ds_vld   <= 1'b1;
            r_ds_addr  <= r_pend_addr[w_gnt];
            r_ds_wr    <= r_pend_wr[w_gnt];
            r_ds_rd    <= r_pend_rd[w_gnt];
            r_ds_wdata <= r_pend_wdata[w_gnt];
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_rr_ptr <= r_gnt;
          r_state  <= w_rsp_fire ? ST_RESP : ST_WAIT_ACK;
`ifdef REGARB_TIMEOUT_EN
          r_cnt    <= '0;
`endif
        end
        ST_WAIT_ACK: begin
          if (w_rsp_fire) begin
            r_state <= ST_RESP;
          end
`ifdef REGARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_rsp_fire) begin
        for (int i = 0; i < REQ_NUM; i++) begin
          if (r_gnt == GNT_W'(i)) begin
            r_up_ack[i] <= 1'b1;
            r_up_err[i] <= w_rsp_err;
            r_up_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= w_rsp_data;
          end
        end
      end
    end
  end

  assign regarb_mst_arb__upstream__ack_vld    = r_up_ack;
  assign regarb_mst_arb__upstream__err        = r_up_err;
  assign regarb_mst_arb__upstream__rd_data    = r_up_rdata;
  assign regarb_mst_arb__downstream__req_vld  = r_ds_vld;
  assign regarb_mst_arb__downstream__addr     = r_ds_addr;
  assign regarb_mst_arb__downstream__wr_en    = r_ds_wr;
  assign regarb_mst_arb__downstream__rd_en    = r_ds_rd;
  assign regarb_mst_arb__downstream__wr_data  = r_ds_wdata;
  assign regarb_mst_arb__downstream__soft_rst = r_ds_srst;

endmodule

// File: doc/regarb_mst_arb.md
Name: regarb_mst_arb

Overview:
- Shares one reg_native_if between REQ_NUM upstream requesters, for example a debug bridge and a CPU bridge.
- Drives the single upstream port of a regdisp dispatcher.
- Latches each requester's one-cycle request and grants in round-robin order.
- Keeps exactly one transaction outstanding downstream and routes ack/err/rd_data back to the granted requester only.

Parameters:
- REQ_NUM, 2, number of requesters; valid range 2..8.
- ADDR_WIDTH, 64, address width.
- DATA_WIDTH, 32, data width.
- TIMEOUT_CYCLES, 1024, cycles spent waiting for ack before an error is forced. Used only with REGARB_TIMEOUT_EN.

Ports:
- regarb_mst_arb_clk  in  1  clock.
- regarb_mst_arb_rst  in  1  synchronous, active-high reset.
- upstream__regarb_mst_arb__req_vld  in  REQ_NUM  one-cycle request pulse per requester.
- upstream__regarb_mst_arb__addr  in  REQ_NUM*ADDR_WIDTH  packed; requester i in slice i.
- upstream__regarb_mst_arb__wr_en  in  REQ_NUM  write strobe, qualified by req_vld.
- upstream__regarb_mst_arb__rd_en  in  REQ_NUM  read strobe, qualified by req_vld.
- upstream__regarb_mst_arb__wr_data  in  REQ_NUM*DATA_WIDTH  write data.
- upstream__regarb_mst_arb__soft_rst  in  REQ_NUM  soft reset request per requester.
- regarb_mst_arb__upstream__ack_vld  out  REQ_NUM  one-cycle completion pulse.
- regarb_mst_arb__upstream__err  out  REQ_NUM  error flag, valid with ack_vld.
- regarb_mst_arb__upstream__rd_data  out  REQ_NUM*DATA_WIDTH  read data, valid with ack_vld.
- regarb_mst_arb__downstream__req_vld  out  1  request to the dispatcher.
- regarb_mst_arb__downstream__addr / wr_en / rd_en / wr_data  out  ADDR_WIDTH / 1 / 1 / DATA_WIDTH  request fields.
- downstream__regarb_mst_arb__ack_vld / err / rd_data  in  1 / 1 / DATA_WIDTH  dispatcher response.
- regarb_mst_arb__downstream__soft_rst  out  1  OR of all upstream soft_rst, registered.

Behaviour:
- Reset: all outputs are 0, pending buffers are cleared, FSM is IDLE, rr_ptr = REQ_NUM-1 so requester 0 wins first.
- Per-requester pending buffer, one deep:
  - req_vld[i] with pend[i]=0 captures addr, wr_en, rd_en and wr_data, and sets pend[i] at the next edge.
  - req_vld[i] with pend[i]=1 is dropped. This is a protocol violation and leaves the stored request unchanged.
- FSM states: IDLE, ISSUE, WAIT_ACK, RESP.
- IDLE, when any pend bit is set:
  - gnt = first pending index after rr_ptr, wrapping modulo REQ_NUM.
  - Load the downstream registers from the pending buffer.
  - Go to ISSUE.
- ISSUE:
  - downstream req_vld = 1 for exactly this cycle.
  - rr_ptr <= gnt.
  - If downstream ack_vld is already high (dispatcher dummy-register ack), capture it and go to RESP.
  - Otherwise go to WAIT_ACK.
- WAIT_ACK:
  - Downstream addr/data are held stable and req_vld is 0.
  - On ack_vld, capture err and rd_data and go to RESP.
- RESP:
  - ack_vld[gnt] = 1 for one cycle, with err[gnt] and rd_data[gnt]; all other requesters' outputs stay 0.
  - Clear pend[gnt] and return to IDLE.
  - A new req_vld[gnt] in the same cycle is accepted, because pend is cleared on that edge.
- Latency with the arbiter idle and pend empty:
  - Upstream pulse at cycle N gives downstream req_vld at N+2.
  - Downstream ack at cycle M gives upstream ack at M+1.
  - Minimum round trip is 3 cycles.
- Downstream ack_vld in IDLE or RESP is a stray/late ack and is ignored.
- Simultaneous requests from several requesters: serviced in rotating order. No requester waits more than REQ_NUM-1 grants.
- rd_data is zero on writes unless the dispatcher returns data; it is passed through unmodified.
- Reset mid-transaction aborts it: no upstream ack is produced and any subsequent downstream ack is ignored.

Optional Feature:
- Macro REGARB_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) is cleared on entry to WAIT_ACK.
  - When it reaches TIMEOUT_CYCLES with no ack, go to RESP with err=1 and rd_data=0.
  - A later ack for that transaction arrives in IDLE or RESP and is ignored.
- Not defined: no counter; WAIT_ACK waits indefinitely.

Decomposition:
- Package regarb_pkg holds:
  - the state enum (IDLE/ISSUE/WAIT_ACK/RESP, 2-bit);
  - a localparam REGARB_GNT_W = clog2(REQ_NUM) helper.
- Sub-module regarb_rr_picker: combinational round-robin pick from a pend vector and rr_ptr.
  - Outputs gnt index and any_vld.
  - Reused by later multi-master blocks.

Test Plan:
- Single read, requester 0, addr 0x0000_0000_2000_0010:
  - downstream req_vld at N+2 with that addr and rd_en=1.
  - Dispatcher acks 3 cycles later with rd_data 0xA5A5_0001, giving ack_vld[0] and rd_data 0xA5A5_0001 one cycle later.
  - ack_vld[1] stays 0.
- Fairness: requesters 0 and 1 pulse in the same cycle, repeated 4 times → grants alternate 0,1,0,1,... and each requester gets exactly 4 acks.
- Same-cycle dummy ack: dispatcher asserts ack_vld with err=1 during the ISSUE cycle → err[gnt]=1 at the next cycle and the FSM returns to IDLE.
- Protocol violation: requester 1 pulses twice while pending with addr 0x100 then 0x200 → only 0x100 goes downstream, and there is exactly one ack.
- Reset asserted in WAIT_ACK, then downstream ack 2 cycles later → no upstream ack and all outputs stay 0.
- REGARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack → err=1, rd_data=0 exactly 8 cycles after entering WAIT_ACK, plus 1 cycle in RESP. A late ack is ignored.
